// File: rtl/t03_hwclk_timer_ctrl.sv
// Hardware clock counter controller: prescaled counter, compare/match IRQ, MMIO req/ack access.
// Optional auto-reload on match is compiled in when T03_HWCLK_AUTORELOAD_EN is defined.
module t03_hwclk_timer_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PS_W  = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata,
    output logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_COUNT  = 2'd1;
    localparam logic [1:0] ADDR_CMP    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic {StIdle, StResp} state_e;

    state_e           r_state;
    logic             r_ack;
    logic [CNT_W-1:0] r_rdata;

    logic             r_en;
    logic             r_irq_en;
    logic [PS_W-1:0]  r_ps;
    logic [PS_W-1:0]  r_ps_cnt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_cmp;
    logic             r_match;

    logic             w_accept;
    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_cmp;
    logic             w_wr_status;
    logic             w_tick;
    logic             w_hit;
    logic             w_ps_chg;
    logic             w_ar;
    logic [PS_W-1:0]  w_ps_new;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_rd_val;
    logic             w_unused;

    assign w_accept    = (r_state == StIdle) && req;
    assign w_wr        = w_accept && we;
    assign w_wr_ctrl   = w_wr && (addr[3:2] == ADDR_CTRL);
    assign w_wr_count  = w_wr && (addr[3:2] == ADDR_COUNT);
    assign w_wr_cmp    = w_wr && (addr[3:2] == ADDR_CMP);
    assign w_wr_status = w_wr && (addr[3:2] == ADDR_STATUS);

    assign w_ps_new  = wdata[8 +: PS_W];
    assign w_ps_chg  = w_wr_ctrl && (w_ps_new != r_ps);
    assign w_tick    = r_en && (r_ps_cnt == r_ps);
    assign w_cnt_inc = r_count + CNT_W'(1);
    // A CPU write to COUNT on the same edge suppresses the match check; CMP is the old value.
    assign w_hit     = w_tick && !w_wr_count && (w_cnt_inc == r_cmp);

    assign w_unused = ^{addr[1:0], wdata};

`ifdef T03_HWCLK_AUTORELOAD_EN
    logic r_ar;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ar <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_ar <= wdata[2];
        end
    end

    assign w_ar = r_ar;
`else
    assign w_ar = 1'b0;
`endif

    always_comb begin
        w_rd_val = '0;
        case (addr[3:2])
            ADDR_CTRL: begin
                w_rd_val[8 +: PS_W] = r_ps;
                w_rd_val[2]         = w_ar;
                w_rd_val[1]         = r_irq_en;
                w_rd_val[0]         = r_en;
            end
            ADDR_COUNT:  w_rd_val    = r_count;
            ADDR_CMP:    w_rd_val    = r_cmp;
            ADDR_STATUS: w_rd_val[0] = r_match;
            default:     w_rd_val    = '0;
        endcase
    end

    // Bus FSM: one-cycle ack; read data captured from pre-edge register values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req) begin
                        r_state <= StResp;
                        r_ack   <= 1'b1;
                        r_rdata <= we ? '0 : w_rd_val;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= StIdle;
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_ps     <= '0;
        end else if (w_wr_ctrl) begin
            r_en     <= wdata[0];
            r_irq_en <= wdata[1];
            r_ps     <= w_ps_new;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ps_cnt <= '0;
        end else if (!r_en || w_tick || w_wr_count || w_ps_chg || (w_wr_ctrl && !wdata[0])) begin
            r_ps_cnt <= '0;
        end else begin
            r_ps_cnt <= r_ps_cnt + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= wdata;
        end else if (w_tick) begin
            r_count <= (w_hit && w_ar) ? '0 : w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cmp <= '1;
        end else if (w_wr_cmp) begin
            r_cmp <= wdata;
        end
    end

    // Set beats a same-edge W1C so a match is never lost.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (w_wr_status && wdata[0]) begin
            r_match <= 1'b0;
        end
    end

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign count = r_count;
    assign irq   = r_match & r_irq_en;

endmodule

// File: tb/tb_t03_hwclk_timer_ctrl.sv
// Self-checking bench for t03_hwclk_timer_ctrl; honours T03_HWCLK_AUTORELOAD_EN like the RTL.
module tb_t03_hwclk_timer_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] count;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] rd_q[$];
    logic [31:0] cnt_q[$];
    logic        irq_q[$];

    t03_hwclk_timer_ctrl #(
        .CNT_W (32),
        .PS_W  (8)
    ) dut (
        .clk   (clk),
        .nrst  (nrst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .count (count),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge where ack is first seen high; read data goes via rd_q.
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input string tag, output int lat);
        logic [31:0] e;
        if (!w) rd_q.push_back(exp_rd);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        lat   = 0;
        do begin
            sample();
            lat++;
        end while (!ack && lat < 8);
        req = 1'b0;
        we  = 1'b0;
        if (!ack) begin
            check_val({tag, "_ack_timeout"}, {31'b0, ack}, 32'h1);
            if (!w) e = rd_q.pop_front();
        end else if (!w) begin
            e = rd_q.pop_front();
            check_val(tag, rdata, e);
        end
    endtask

    int          lat;
    int          n;
    logic [31:0] prev;
    logic        seen;

    initial begin
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack", {31'b0, ack}, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);
        check_val("rst_count", count, 32'h0);
        check_val("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        bus(1'b0, 4'h8, 32'h0, 32'hFFFF_FFFF, "rst_rd_cmp", lat);
        bus(1'b0, 4'h0, 32'h0, 32'h0, "rst_rd_ctrl", lat);
        bus(1'b0, 4'hC, 32'h0, 32'h0, "rst_rd_status", lat);
        bus(1'b0, 4'h7, 32'h0, 32'h0, "rst_rd_count", lat);

        // Access and prescale 3
        repeat (2) sample();
        bus(1'b1, 4'h0, 32'h0000_0301, 32'h0, "wr_ctrl", lat);
        check_val("ack_latency", lat, 32'd1);
        sample();
        check_val("ack_drop", {31'b0, ack}, 32'h0);
        check_val("rdata_drop", rdata, 32'h0);
        prev = count;
        n = 0;
        while (count == prev && n < 20) begin
            sample();
            n++;
        end
        prev = count;
        n = 0;
        while (count == prev && n < 20) begin
            sample();
            n++;
        end
        check_val("ps_period", n, 32'd4);
        bus(1'b0, 4'h0, 32'h0, 32'h0000_0301, "rd_ctrl", lat);
        bus(1'b1, 4'h0, 32'h0, 32'h0, "stop", lat);
        bus(1'b1, 4'h4, 32'h1234_5678, 32'h0, "wr_count", lat);
        bus(1'b0, 4'h4, 32'h0, 32'h1234_5678, "rd_count", lat);

        // Compare match and interrupt
        bus(1'b1, 4'h4, 32'h0, 32'h0, "m_count", lat);
        bus(1'b1, 4'h8, 32'd5, 32'h0, "m_cmp", lat);
        bus(1'b0, 4'hA, 32'h0, 32'd5, "m_rd_cmp", lat);
        bus(1'b1, 4'h0, 32'h3, 32'h0, "m_ctrl", lat);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            sample();
            n++;
            if (count == 32'd4) check_val("irq_pre", {31'b0, irq}, 32'h0);
            if (count == 32'd5) begin
                check_val("irq_match", {31'b0, irq}, 32'h1);
                seen = 1'b1;
            end
        end
        if (!seen) check_val("match_timeout", count, 32'd5);
        bus(1'b1, 4'hC, 32'h1, 32'h0, "w1c", lat);
        check_val("irq_w1c", {31'b0, irq}, 32'h0);
        bus(1'b0, 4'hC, 32'h0, 32'h0, "rd_status_clr", lat);
        bus(1'b1, 4'h0, 32'h0, 32'h0, "m_stop", lat);

        // Wrap without match
        bus(1'b1, 4'h8, 32'd10, 32'h0, "wr_cmp10", lat);
        bus(1'b1, 4'h4, 32'hFFFF_FFFE, 32'h0, "wr_fffe", lat);
        bus(1'b1, 4'h0, 32'h1, 32'h0, "wrap_run", lat);
        check_val("wrap0", count, 32'hFFFF_FFFE);
        sample();
        check_val("wrap1", count, 32'hFFFF_FFFF);
        sample();
        check_val("wrap2", count, 32'h0);
        bus(1'b1, 4'h0, 32'h0, 32'h0, "wrap_stop", lat);
        bus(1'b0, 4'hC, 32'h0, 32'h0, "wrap_nomatch", lat);

        // Collisions
        bus(1'b1, 4'h8, 32'h8000_0000, 32'h0, "c_cmp", lat);
        bus(1'b1, 4'h0, 32'h1, 32'h0, "c_run", lat);
        bus(1'b1, 4'h4, 32'h100, 32'h0, "c_wr_count", lat);
        check_val("coll_count", count, 32'h100);
        sample();
        check_val("coll_count_next", count, 32'h101);
        bus(1'b1, 4'h0, 32'h0, 32'h0, "c_stop", lat);
        bus(1'b1, 4'h4, 32'h0, 32'h0, "c_zero", lat);
        bus(1'b1, 4'h8, 32'd8, 32'h0, "c_cmp8", lat);
        bus(1'b1, 4'h0, 32'h3, 32'h0, "c_run_irq", lat);
        n = 0;
        while (count != 32'd7 && n < 20) begin
            sample();
            n++;
        end
        check_val("coll_reach7", count, 32'd7);
        bus(1'b1, 4'hC, 32'h1, 32'h0, "c_w1c", lat);
        check_val("coll_w1c_irq", {31'b0, irq}, 32'h1);
        bus(1'b0, 4'hC, 32'h0, 32'h1, "coll_w1c_status", lat);
        bus(1'b1, 4'hC, 32'h1, 32'h0, "c_clr", lat);
        bus(1'b1, 4'h0, 32'h0, 32'h0, "c_stop2", lat);

        // Auto-reload (or free-run when not built in)
        bus(1'b1, 4'h4, 32'h0, 32'h0, "ar_zero", lat);
        bus(1'b1, 4'h8, 32'd3, 32'h0, "ar_cmp", lat);
        for (int i = 0; i < 6; i++) begin
`ifdef T03_HWCLK_AUTORELOAD_EN
            cnt_q.push_back(32'(i % 3));
`else
            cnt_q.push_back(32'(i));
`endif
            irq_q.push_back(i >= 3);
        end
        bus(1'b1, 4'h0, 32'h7, 32'h0, "ar_run", lat);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) sample();
            check_val($sformatf("ar_count%0d", i), count, cnt_q.pop_front());
            check_val($sformatf("ar_irq%0d", i), {31'b0, irq}, {31'b0, irq_q.pop_front()});
        end
`ifdef T03_HWCLK_AUTORELOAD_EN
        bus(1'b0, 4'h0, 32'h0, 32'h7, "ar_rd_ctrl", lat);
`else
        bus(1'b0, 4'h0, 32'h0, 32'h3, "ar_rd_ctrl", lat);
`endif

        // Async reset in the middle of an access while counting with irq high
        repeat (2) sample();
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 4'h8;
        sample();
        check_val("mid_ack", {31'b0, ack}, 32'h1);
        #2;
        nrst = 1'b0;
        #1;
        req = 1'b0;
        check_val("mid_rst_ack", {31'b0, ack}, 32'h0);
        check_val("mid_rst_irq", {31'b0, irq}, 32'h0);
        check_val("mid_rst_count", count, 32'h0);
        check_val("mid_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        bus(1'b0, 4'h8, 32'h0, 32'hFFFF_FFFF, "post_rst_cmp", lat);
        bus(1'b0, 4'h0, 32'h0, 32'h0, "post_rst_ctrl", lat);
        bus(1'b0, 4'hC, 32'h0, 32'h0, "post_rst_status", lat);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
